// File: rtl/ifu_pkg.sv
// Shared types and default widths for the instruction fetch unit, the
// instruction register and the core control unit.
package ifu_pkg;

  localparam int INSTR_WIDTH_DEF  = 17;
  localparam int PC_WIDTH_DEF     = 8;
  localparam int OPCODE_WIDTH_DEF = 5;

  localparam logic [OPCODE_WIDTH_DEF-1:0] HALT_OPCODE = '1;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    WRITE,
    HALTED
  } ifu_state_e;

  function automatic logic is_busy_state(input ifu_state_e s);
    return (s == ISSUE) || (s == WAIT) || (s == WRITE);
  endfunction

endpackage

// File: rtl/ifu_pc_counter.sv
// Program counter register: synchronous active-low reset, load has priority
// over increment, increment wraps modulo 2^PC_WIDTH.
module ifu_pc_counter
  import ifu_pkg::*;
#(
  parameter int PC_WIDTH = PC_WIDTH_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [PC_WIDTH-1:0] load_val,
  input  logic                inc,
  output logic [PC_WIDTH-1:0] pc
);

  logic [PC_WIDTH-1:0] pc_reg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_reg <= '0;
    end else if (load) begin
      pc_reg <= load_val;
    end else if (inc) begin
      pc_reg <= pc_reg + PC_WIDTH'(1);
    end
  end

  assign pc = pc_reg;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: one synchronous-memory read per request, result
// written to the instruction register. Optional halt detection: IFU_HALT_DETECT_EN.
module instr_fetch_unit
  import ifu_pkg::*;
#(
  parameter int INSTR_WIDTH  = INSTR_WIDTH_DEF,
  parameter int PC_WIDTH     = PC_WIDTH_DEF,
  parameter int OPCODE_WIDTH = OPCODE_WIDTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   fetch_req,
  input  logic                   pc_load,
  input  logic [PC_WIDTH-1:0]    pc_load_val,
  output logic                   imem_rd_en,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  output logic                   ir_write,
  output logic [INSTR_WIDTH-1:0] ir_data,
  output logic [PC_WIDTH-1:0]    pc,
  output logic                   busy,
  output logic                   fetch_done,
  output logic                   halted
);

`ifdef IFU_HALT_DETECT_EN
  localparam bit HALT_DETECT = 1'b1;
`else
  localparam bit HALT_DETECT = 1'b0;
`endif

  ifu_state_e state_reg, state_next;

  logic [INSTR_WIDTH-1:0]  buffer_reg, buffer_next;
  logic [PC_WIDTH-1:0]     imem_addr_reg, imem_addr_next;
  logic                    imem_rd_en_reg, imem_rd_en_next;
  logic                    ir_write_reg, ir_write_next;
  logic                    busy_reg, busy_next;
  logic                    halted_reg, halted_next;
  logic [OPCODE_WIDTH-1:0] opcode;
  logic [PC_WIDTH-1:0]     pc_target;
  logic                    pc_load_en, pc_inc, halt_hit;

  assign opcode     = buffer_reg[INSTR_WIDTH-1 -: OPCODE_WIDTH];
  assign halt_hit   = HALT_DETECT && (state_reg == WRITE) && (opcode == HALT_OPCODE);
  assign pc_load_en = pc_load && ((state_reg == IDLE) || (state_reg == HALTED));
  assign pc_inc     = (state_reg == WRITE) && !halt_hit;
  // Address the fetch with the freshly loaded PC when load and request coincide.
  assign pc_target  = pc_load_en ? pc_load_val : pc;

  ifu_pc_counter #(
    .PC_WIDTH (PC_WIDTH)
  ) u_pc_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (pc_load_en),
    .load_val (pc_load_val),
    .inc      (pc_inc),
    .pc       (pc)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg      <= IDLE;
      buffer_reg     <= '0;
      imem_addr_reg  <= '0;
      imem_rd_en_reg <= 1'b0;
      ir_write_reg   <= 1'b0;
      busy_reg       <= 1'b0;
      halted_reg     <= 1'b0;
    end else begin
      state_reg      <= state_next;
      buffer_reg     <= buffer_next;
      imem_addr_reg  <= imem_addr_next;
      imem_rd_en_reg <= imem_rd_en_next;
      ir_write_reg   <= ir_write_next;
      busy_reg       <= busy_next;
      halted_reg     <= halted_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (fetch_req) state_next = ISSUE;
      ISSUE:   state_next = WAIT;
      WAIT:    state_next = WRITE;
      WRITE:   state_next = halt_hit ? HALTED : IDLE;
      HALTED:  if (pc_load) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs are registered, so they are decoded from the state being entered.
  always_comb begin
    imem_rd_en_next = (state_next == ISSUE);
    imem_addr_next  = (state_next == ISSUE) ? pc_target : imem_addr_reg;
    ir_write_next   = (state_next == WRITE);
    busy_next       = is_busy_state(state_next);
    halted_next     = (state_next == HALTED);
    buffer_next     = (state_reg == WAIT) ? imem_rdata : buffer_reg;
  end

  assign imem_rd_en = imem_rd_en_reg;
  assign imem_addr  = imem_addr_reg;
  assign ir_write   = ir_write_reg;
  assign fetch_done = ir_write_reg;
  assign ir_data    = buffer_reg;
  assign busy       = busy_reg;
  assign halted     = halted_reg;

endmodule
